// File: rtl/pwm_audio_multich.sv
// pwm_audio_multich: multi-channel edge/center-aligned PWM with double-buffered duty,
// period and mode registers that reload only at frame wrap.
module pwm_audio_multich #(
  parameter int N_CH = 2,
  parameter int CNT_W = 17,
  parameter int CH_W = 1,
  parameter int PER_INIT = 79999
) (
  input  logic             clk,
  input  logic             reset_central_n,
  input  logic             enable,
  input  logic             center_mode,
  input  logic [CNT_W-1:0] period,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             wr_ack,
  output logic [N_CH-1:0]  pwm_out,
  output logic [CNT_W-1:0] cnt,
  output logic             period_start
);
  logic dir, dir_nx, mode_act, started, ps_q, top, wrap, wr_ok;
  logic [CNT_W-1:0] per_act, cnt_nx;
  logic [CNT_W-1:0] shadow [N_CH];
  logic [CNT_W-1:0] duty_act [N_CH];
  logic [N_CH-1:0] pwm_nx;

  assign top = cnt >= per_act;
  assign wr_ok = wr_en && (int'(wr_ch) < N_CH);
  assign wrap = enable && (cnt_nx == '0);
  // The very first enabled cycle after reset is itself a frame start at cnt=0.
  assign period_start = ps_q || (!started && enable && reset_central_n);

  always_comb begin
    cnt_nx = top ? '0 : cnt + 1'b1;
    dir_nx = 1'b0;
    if (mode_act && !dir) begin
      cnt_nx = top ? ((cnt == '0) ? '0 : cnt - 1'b1) : cnt + 1'b1;
      dir_nx = top && (cnt > CNT_W'(1));
    end else if (mode_act) begin
      cnt_nx = (cnt <= CNT_W'(1)) ? '0 : cnt - 1'b1;
      dir_nx = cnt > CNT_W'(1);
    end
  end

  always_comb begin
    pwm_nx = '0;
    for (int i = 0; i < N_CH; i++) pwm_nx[i] = enable && (cnt < duty_act[i]);
  end

  always_ff @(posedge clk or negedge reset_central_n) begin
    if (!reset_central_n) begin
      cnt <= '0;
      dir <= 1'b0;
      per_act <= CNT_W'(PER_INIT);
      mode_act <= 1'b0;
      started <= 1'b0;
      ps_q <= 1'b0;
      wr_ack <= 1'b0;
      pwm_out <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      pwm_out <= pwm_nx;
      wr_ack <= wr_ok;
      ps_q <= wrap;
      if (enable) begin
        cnt <= cnt_nx;
        dir <= dir_nx;
        started <= 1'b1;
      end
      if (wrap) begin
        per_act <= period;
        mode_act <= center_mode;
      end
      // Wrap captures the pre-write shadow; a same-cycle write lands one frame later.
      for (int i = 0; i < N_CH; i++) begin
        if (wrap) duty_act[i] <= shadow[i];
        if (wr_ok && int'(wr_ch) == i) shadow[i] <= wr_duty;
      end
    end
  end
endmodule

// File: tb/tb_pwm_audio_multich.sv
// tb_pwm_audio_multich: frame-level table checks, directed corner sequences and a
// cycle-by-cycle reference model driven by random stimulus.
module tb_pwm_audio_multich;
  logic clk, reset_central_n, enable, center_mode, wr_en, wr_ack, period_start;
  logic [16:0] period, wr_duty, cnt;
  logic [1:0] wr_ch;
  logic [2:0] pwm_out;
  int total = 0, bad = 0;
  bit chk_on = 0;

  pwm_audio_multich #(.N_CH(3), .CNT_W(17), .CH_W(2), .PER_INIT(12)) dut (
    .clk(clk), .reset_central_n(reset_central_n), .enable(enable),
    .center_mode(center_mode), .period(period), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .wr_ack(wr_ack), .pwm_out(pwm_out), .cnt(cnt),
    .period_start(period_start)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame, frame length from P and mode.
  int m_ph, m_P, m_duty[3], m_sh[3];
  bit m_mode, m_first, m_ps, m_ack;
  logic [2:0] m_pwm;

  function automatic int m_cnt();
    return m_mode ? ((m_ph <= m_P) ? m_ph : 2 * m_P - m_ph) : m_ph;
  endfunction

  function automatic int m_len();
    return m_mode ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_P = 12; m_mode = 0; m_first = 1; m_ps = 0; m_ack = 0; m_pwm = '0;
    for (int i = 0; i < 3; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
  endtask

  task automatic model_step();
    int c;
    bit w;
    c = m_cnt();
    w = 0;
    for (int i = 0; i < 3; i++) m_pwm[i] = enable && (c < m_duty[i]);
    m_ack = wr_en && (int'(wr_ch) < 3);
    if (enable) begin
      m_first = 0;
      if (m_ph + 1 >= m_len()) begin
        w = 1; m_ph = 0; m_P = int'(period); m_mode = center_mode;
        for (int i = 0; i < 3; i++) m_duty[i] = m_sh[i];
      end else m_ph++;
    end
    m_ps = w;
    if (m_ack) m_sh[wr_ch] = int'(wr_duty);
  endtask

  always @(posedge clk or negedge reset_central_n)
    if (!reset_central_n) model_reset(); else model_step();

  always @(negedge clk) begin
    #3;
    if (chk_on) begin
      chk("m_cnt", int'(cnt), m_cnt());
      chk("m_pwm", int'(pwm_out), int'(m_pwm));
      chk("m_ack", int'(wr_ack), int'(m_ack));
      chk("m_ps", int'(period_start), int'(m_ps | (m_first & enable & reset_central_n)));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ps();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (period_start) begin ok = 1; break; end
    end
    chk("ps_wait", int'(ok), 1);
  endtask

  task automatic wait_cnt(input int v);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (int'(cnt) == v) begin ok = 1; break; end
      tick();
    end
    chk("cnt_wait", int'(ok), 1);
  endtask

  task automatic configure(input int per, input bit cm, input int d0, input int d1);
    tick();
    period = 17'(per); center_mode = cm;
    wr_en = 1; wr_ch = 0; wr_duty = 17'(d0);
    tick();
    wr_ch = 1; wr_duty = 17'(d1);
    tick();
    wr_en = 0;
  endtask

  task automatic frame_stats(input int l, output int h0, output int h1, output int len);
    h0 = 0; h1 = 0; len = 0;
    for (int k = 0; k < l; k++) begin
      tick();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (period_start && len == 0) len = k + 1;
    end
  endtask

  typedef struct {int per; bit cm; int d0, d1, len, h0, h1;} vec_t;
  vec_t tbl[7];

  initial begin
    int n, h0, h1, len;
    tbl[0] = '{9, 0, 3, 8, 10, 3, 8};
    tbl[1] = '{4, 1, 2, 4, 8, 3, 7};
    tbl[2] = '{9, 0, 0, 10, 10, 0, 10};
    tbl[3] = '{4, 1, 0, 5, 8, 0, 8};
    tbl[4] = '{0, 0, 1, 0, 1, 1, 0};
    tbl[5] = '{1, 1, 1, 2, 2, 1, 2};
    tbl[6] = '{3, 0, 2, 4, 4, 2, 4};
    reset_central_n = 0; enable = 0; center_mode = 0; period = 9;
    wr_en = 0; wr_ch = 0; wr_duty = 0; chk_on = 1;
    repeat (3) tick();
    reset_central_n = 1; enable = 1;
    #1;
    chk("first_ps", int'(period_start), 1);
    chk("first_cnt", int'(cnt), 0);
    n = 0;
    do begin tick(); n++; end while (!period_start && n < 100);
    chk("init_frame", n, 13);
    for (int t = 0; t < 7; t++) begin
      configure(tbl[t].per, tbl[t].cm, tbl[t].d0, tbl[t].d1);
      wait_ps(); wait_ps();
      frame_stats(tbl[t].len, h0, h1, len);
      chk($sformatf("tbl%0d_len", t), len, tbl[t].len);
      chk($sformatf("tbl%0d_h0", t), h0, tbl[t].h0);
      chk($sformatf("tbl%0d_h1", t), h1, tbl[t].h1);
    end
    configure(9, 0, 3, 8);
    wait_ps(); wait_ps();
    frame_stats(10, h0, h1, len);
    chk("db_pre", h0, 3);
    repeat (3) tick();
    wr_en = 1; wr_ch = 0; wr_duty = 7;
    tick();
    chk("db_ack", int'(wr_ack), 1);
    wr_en = 0; h0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      h0 += int'(pwm_out[0]);
      if (period_start) break;
    end
    chk("db_cur", h0, 0);
    frame_stats(10, h0, h1, len);
    chk("db_next", h0, 7);
    wait_cnt(9);
    wr_en = 1; wr_ch = 0; wr_duty = 5;
    tick();
    chk("wrap_ps", int'(period_start), 1);
    chk("wrap_ack", int'(wr_ack), 1);
    wr_en = 0;
    frame_stats(10, h0, h1, len);
    chk("wrap_old", h0, 7);
    frame_stats(10, h0, h1, len);
    chk("wrap_new", h0, 5);
    wait_cnt(5);
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_cnt", int'(cnt), 5);
      chk("frz_pwm", int'(pwm_out), 0);
      chk("frz_ps", int'(period_start), 0);
      if (i == 2) begin chk("frz_ack", int'(wr_ack), 1); wr_en = 0; end
      if (i == 1) begin wr_en = 1; wr_ch = 1; wr_duty = 8; end
    end
    enable = 1;
    tick();
    chk("resume6", int'(cnt), 6);
    tick();
    chk("resume7", int'(cnt), 7);
    configure(9, 0, 3, 8);
    wr_en = 1; wr_ch = 3; wr_duty = 1;
    tick();
    chk("badch_ack", int'(wr_ack), 0);
    wr_en = 0;
    wait_ps(); wait_ps();
    frame_stats(10, h0, h1, len);
    chk("badch_h0", h0, 3);
    wait_cnt(1);
    wr_en = 1; wr_ch = 1; wr_duty = 8;
    @(posedge clk);
    #2 reset_central_n = 0;
    #1;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ack", int'(wr_ack), 0);
    chk("rst_ps", int'(period_start), 0);
    wr_en = 0;
    repeat (2) tick();
    reset_central_n = 1;
    #1;
    chk("rst_first_ps", int'(period_start), 1);
    n = 0;
    do begin tick(); n++; end while (!period_start && n < 100);
    chk("rst_frame", n, 13);
    for (int i = 0; i < 2000; i++) begin
      tick();
      enable = ($urandom % 8) != 0;
      wr_en = ($urandom % 3) == 0;
      wr_ch = 2'($urandom_range(0, 3));
      wr_duty = 17'($urandom_range(0, 9));
      if ($urandom % 20 == 0) period = 17'($urandom_range(0, 6));
      if ($urandom % 25 == 0) center_mode = 1'($urandom % 2);
    end
    tick();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
